ysyx_22050133_idu_sb: RTL and testbench
=======================================

# ysyx_22050133_idu_sb

Pipelined, parametrised RV64I/RV32I decode stage for the ysyx_22050133 core. It sits between IFU and EXU and holds one instruction in an output pipeline register under a valid/ready handshake. It contains an XLEN-wide register file with write-back bypass, and a per-register pending-write scoreboard that stalls read-after-write hazards. A flush input discards the buffered instruction.

## Interface
Parameters:
- XLEN, 64, datapath width (32 or 64); immediates sign-extend to XLEN
- NREG, 32, architectural registers (16 for RV-E); index width AW = clog2(NREG)
- SB_CNT_W, 2, width of each scoreboard pending counter

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  IFU offers in_inst/in_pc
- in_ready  out  1  stage accepts this cycle
- in_inst  in  32  instruction word
- in_pc  in  XLEN  instruction address
- out_valid  out  1  decoded instruction held
- out_ready  in  1  EXU accepts
- out_pc  out  XLEN  latched pc
- out_inst  out  32  latched instruction
- out_rs1data, out_rs2data  out  XLEN  operands, 0 when the source is unused
- out_imm  out  XLEN  I/S/B/U/J immediate, 0 for R-type/illegal
- out_rd  out  AW  destination index
- out_rdwen  out  1  instruction writes rd (never for rd=0)
- out_illegal  out  1  unsupported opcode
- wb_en  in  1  write-back strobe
- wb_rd  in  AW  write-back index
- wb_data  in  XLEN  write-back value
- flush  in  1  discard the held instruction

## Operation
- Decode from the instruction fields:
  - rdwen for LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP-IMM-32, OP, OP-32, and SYSTEM with funct3≠0.
  - rs1 used for JALR, BRANCH, LOAD, STORE, OP-IMM(-32), OP(-32), and SYSTEM with funct3∈{1,2,3}.
  - rs2 used for BRANCH, STORE, OP(-32).
- OP-IMM-32/OP-32 are illegal when XLEN=32.
- MISC-MEM and SYSTEM are legal.
- Any other opcode sets illegal=1 and forces rdwen=0 and operands=0.
- Register indices ≥NREG are illegal.
- Register file:
  - x0 reads 0. A write occurs when wb_en && wb_rd≠0.
  - Read bypass: if wb_en && wb_rd==rs && rs≠0, the operand is wb_data.
  - Operands are sampled at accept time into the output register.
- Scoreboard: pending[r] counters.
  - +1 on accept when rdwen.
  - −1 on wb_en for wb_rd≠0 (wb_rd≠0 is guaranteed only for pending registers).
  - −1 on flush while out_valid && out_rdwen, for the flushed out_rd.
  - Simultaneous +1 and −1 on the same register leaves it unchanged.
- hazard = (used rs with pending[rs]≠0, unless pending[rs]==1 && wb_en && wb_rd==rs) OR (rdwen && pending[rd] == 2^SB_CNT_W−1).
- in_ready = !flush && !hazard && (!out_valid || out_ready). Accept = in_valid && in_ready.
- Output register:
  - Loads on accept.
  - Clears out_valid on out_ready without accept, or on flush.
  - Holds stable while out_valid && !out_ready.
- flush has priority over out_ready and accept. No accept occurs in a flush cycle.

## Timing
- Reset clears out_valid, out_rdwen, out_illegal, all out_* data, all pending counters and all registers to 0.
- in_ready is combinational from in_inst, flush, out_valid, out_ready, wb_* and pending. out_* are registered.
- Latency: accept in cycle N gives out_valid=1 in cycle N+1.
- Throughput: 1 instruction/cycle absent hazards.
- Back-to-back dependence: the dependent instruction stalls until the producer's wb_en cycle. It is accepted in that same cycle via bypass.
- Register write is visible to bypass in the write cycle and to the array from the next cycle.
- Reset asserted mid-stall discards everything. The first accept can occur in the first cycle after deassertion.

## Test plan
- Accept 0x00500093 (addi x1,x0,5) -> next cycle: out_rd=1, out_rdwen=1, out_imm=5, out_rs1data=0, pending[1]=1.
- Hold out_ready=1, then offer 0xfff08113 (addi x2,x1,-1):
  - in_ready=0 until wb_en=1, wb_rd=1, wb_data=5.
  - Accepted in that cycle with out_rs1data=5 and out_imm=0xFFFF_FFFF_FFFF_FFFF; pending[1]=0, pending[2]=1.
- Accept 0x123451b7 (lui x3,0x12345) -> out_imm=0x0000_0000_1234_5000. Repeat with XLEN=32 -> 0x1234_5000. 0x0000001b under XLEN=32 -> out_illegal=1.
- wb_en=1, wb_rd=0, wb_data=0xDEAD -> x0 still reads 0. Offer 0x00000000 -> out_illegal=1, out_rdwen=0, pending unchanged.
- SB_CNT_W=1: accept an x1 writer; a second x1 writer -> in_ready=0 until x1 write-back.
- Hold out_valid with out_rdwen=1, rd=5, out_ready=0, then pulse flush:
  - in_ready=0 during flush; out_valid=0 next cycle; pending[5] returns to 0.
  - Then assert rst mid-stall -> all outputs 0.

Source files
------------

// File: rtl/ysyx_22050133_idu_sb.sv
// Decode stage: instruction decode, register file with write-back bypass, and a
// per-register pending-write scoreboard that stalls read-after-write hazards.
module ysyx_22050133_idu_sb #(
  parameter int XLEN     = 64,
  parameter int NREG     = 32,
  parameter int SB_CNT_W = 2,
  localparam int AW      = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_inst,
  output logic [XLEN-1:0] out_rs1data,
  output logic [XLEN-1:0] out_rs2data,
  output logic [XLEN-1:0] out_imm,
  output logic [AW-1:0]   out_rd,
  output logic            out_rdwen,
  output logic            out_illegal,
  input  logic            wb_en,
  input  logic [AW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush
);

  localparam logic [6:0] OP_LUI      = 7'h37;
  localparam logic [6:0] OP_AUIPC    = 7'h17;
  localparam logic [6:0] OP_JAL      = 7'h6f;
  localparam logic [6:0] OP_JALR     = 7'h67;
  localparam logic [6:0] OP_BRANCH   = 7'h63;
  localparam logic [6:0] OP_LOAD     = 7'h03;
  localparam logic [6:0] OP_STORE    = 7'h23;
  localparam logic [6:0] OP_IMM      = 7'h13;
  localparam logic [6:0] OP_IMM_32   = 7'h1b;
  localparam logic [6:0] OP_OP       = 7'h33;
  localparam logic [6:0] OP_OP_32    = 7'h3b;
  localparam logic [6:0] OP_MISC_MEM = 7'h0f;
  localparam logic [6:0] OP_SYSTEM   = 7'h73;

  localparam logic [SB_CNT_W-1:0] CNT_MAX = '1;
  localparam logic [SB_CNT_W-1:0] CNT_ONE = SB_CNT_W'(1);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rd_f, rs1_f, rs2_f;
  logic [AW-1:0] rd_i, rs1_i, rs2_i;
  logic [63:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opcode = in_inst[6:0];
  assign funct3 = in_inst[14:12];
  assign rd_f   = in_inst[11:7];
  assign rs1_f  = in_inst[19:15];
  assign rs2_f  = in_inst[24:20];
  assign rd_i   = rd_f[AW-1:0];
  assign rs1_i  = rs1_f[AW-1:0];
  assign rs2_i  = rs2_f[AW-1:0];

  // Immediates are built at 64 bits and truncated, so XLEN=32 needs no special case.
  assign imm_i = {{52{in_inst[31]}}, in_inst[31:20]};
  assign imm_s = {{52{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
  assign imm_b = {{51{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
  assign imm_u = {{32{in_inst[31]}}, in_inst[31:12], 12'b0};
  assign imm_j = {{43{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};

  logic        known, rdw, u1, u2;
  logic [63:0] imm_raw;

  always_comb begin
    known   = 1'b1;
    rdw     = 1'b0;
    u1      = 1'b0;
    u2      = 1'b0;
    imm_raw = '0;
    case (opcode)
      OP_LUI, OP_AUIPC: begin rdw = 1'b1; imm_raw = imm_u; end
      OP_JAL:           begin rdw = 1'b1; imm_raw = imm_j; end
      OP_JALR, OP_LOAD, OP_IMM: begin rdw = 1'b1; u1 = 1'b1; imm_raw = imm_i; end
      OP_BRANCH:        begin u1 = 1'b1; u2 = 1'b1; imm_raw = imm_b; end
      OP_STORE:         begin u1 = 1'b1; u2 = 1'b1; imm_raw = imm_s; end
      OP_IMM_32: begin
        known = (XLEN != 32); rdw = 1'b1; u1 = 1'b1; imm_raw = imm_i;
      end
      OP_OP:            begin rdw = 1'b1; u1 = 1'b1; u2 = 1'b1; end
      OP_OP_32:         begin known = (XLEN != 32); rdw = 1'b1; u1 = 1'b1; u2 = 1'b1; end
      OP_MISC_MEM:      imm_raw = imm_i;
      OP_SYSTEM: begin
        rdw = (funct3 != 3'd0);
        u1  = (funct3 == 3'd1) || (funct3 == 3'd2) || (funct3 == 3'd3);
        imm_raw = imm_i;
      end
      default:          known = 1'b0;
    endcase
  end

  logic            bad_idx, dec_illegal, dec_rdwen, use_rs1, use_rs2;
  logic [XLEN-1:0] dec_imm;

  assign bad_idx     = (rdw && int'(rd_f) >= NREG) || (u1 && int'(rs1_f) >= NREG) ||
                       (u2 && int'(rs2_f) >= NREG);
  assign dec_illegal = !known || bad_idx;
  assign dec_rdwen   = rdw && !dec_illegal && (rd_f != 5'd0);
  assign use_rs1     = u1 && !dec_illegal;
  assign use_rs2     = u2 && !dec_illegal;
  assign dec_imm     = dec_illegal ? '0 : imm_raw[XLEN-1:0];

  logic [XLEN-1:0]     regs      [NREG];
  logic [SB_CNT_W-1:0] pending   [NREG];
  logic [SB_CNT_W-1:0] pend_next [NREG];
  logic [XLEN-1:0]     rs1_val, rs2_val;

  // Operand read with same-cycle write-back bypass; x0 and unused sources read 0.
  always_comb begin
    rs1_val = '0;
    rs2_val = '0;
    if (use_rs1 && rs1_i != '0)
      rs1_val = (wb_en && wb_rd == rs1_i) ? wb_data : regs[rs1_i];
    if (use_rs2 && rs2_i != '0)
      rs2_val = (wb_en && wb_rd == rs2_i) ? wb_data : regs[rs2_i];
  end

  logic haz1, haz2, haz_full, hazard, accept;

  // A pending source is released in the cycle its last outstanding write lands.
  assign haz1     = use_rs1 && pending[rs1_i] != '0 &&
                    !(pending[rs1_i] == CNT_ONE && wb_en && wb_rd == rs1_i);
  assign haz2     = use_rs2 && pending[rs2_i] != '0 &&
                    !(pending[rs2_i] == CNT_ONE && wb_en && wb_rd == rs2_i);
  assign haz_full = dec_rdwen && pending[rd_i] == CNT_MAX;
  assign hazard   = haz1 || haz2 || haz_full;
  assign in_ready = !flush && !hazard && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      if (r == 0) begin
        pend_next[r] = '0;
      end else begin
        pend_next[r] = pending[r]
                     + SB_CNT_W'(accept && dec_rdwen && rd_i == AW'(r))
                     - SB_CNT_W'(wb_en && wb_rd == AW'(r))
                     - SB_CNT_W'(flush && out_valid && out_rdwen && out_rd == AW'(r));
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        pending[r] <= '0;
        regs[r]    <= '0;
      end
    end else begin
      for (int r = 0; r < NREG; r++) pending[r] <= pend_next[r];
      if (wb_en && wb_rd != '0) regs[wb_rd] <= wb_data;
    end
  end

  // Flush wins over both a new accept (blocked via in_ready) and a drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_pc      <= '0;
      out_inst    <= '0;
      out_rs1data <= '0;
      out_rs2data <= '0;
      out_imm     <= '0;
      out_rd      <= '0;
      out_rdwen   <= 1'b0;
      out_illegal <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      out_pc      <= in_pc;
      out_inst    <= in_inst;
      out_rs1data <= rs1_val;
      out_rs2data <= rs2_val;
      out_imm     <= dec_imm;
      out_rd      <= rd_i;
      out_rdwen   <= dec_rdwen;
      out_illegal <= dec_illegal;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ysyx_22050133_idu_sb.sv
// Scoreboard bench for the decode stage: a 64-bit instance (2-bit counters) and
// a 32-bit instance (1-bit counters) driven by per-scenario tasks.
module tb_ysyx_22050133_idu_sb;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
    logic [63:0] rs1;
    logic [63:0] rs2;
    logic [63:0] imm;
    logic [4:0]  rd;
    logic        rdwen;
    logic        illegal;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        a_in_valid = 0, a_in_ready, a_out_valid, a_out_ready = 0;
  logic [31:0] a_in_inst = 0, a_out_inst;
  logic [63:0] a_in_pc = 0, a_out_pc, a_out_rs1data, a_out_rs2data, a_out_imm, a_wb_data = 0;
  logic [4:0]  a_out_rd, a_wb_rd = 0;
  logic        a_out_rdwen, a_out_illegal, a_wb_en = 0, a_flush = 0;

  logic        b_in_valid = 0, b_in_ready, b_out_valid, b_out_ready = 0;
  logic [31:0] b_in_inst = 0, b_out_inst;
  logic [31:0] b_in_pc = 0, b_out_pc, b_out_rs1data, b_out_rs2data, b_out_imm, b_wb_data = 0;
  logic [4:0]  b_out_rd, b_wb_rd = 0;
  logic        b_out_rdwen, b_out_illegal, b_wb_en = 0, b_flush = 0;

  ysyx_22050133_idu_sb #(.XLEN(64), .NREG(32), .SB_CNT_W(2)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_inst(a_in_inst), .in_pc(a_in_pc), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_pc(a_out_pc), .out_inst(a_out_inst), .out_rs1data(a_out_rs1data),
    .out_rs2data(a_out_rs2data), .out_imm(a_out_imm), .out_rd(a_out_rd),
    .out_rdwen(a_out_rdwen), .out_illegal(a_out_illegal), .wb_en(a_wb_en),
    .wb_rd(a_wb_rd), .wb_data(a_wb_data), .flush(a_flush)
  );

  ysyx_22050133_idu_sb #(.XLEN(32), .NREG(32), .SB_CNT_W(1)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_inst(b_in_inst), .in_pc(b_in_pc), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_pc(b_out_pc), .out_inst(b_out_inst), .out_rs1data(b_out_rs1data),
    .out_rs2data(b_out_rs2data), .out_imm(b_out_imm), .out_rd(b_out_rd),
    .out_rdwen(b_out_rdwen), .out_illegal(b_out_illegal), .wb_en(b_wb_en),
    .wb_rd(b_wb_rd), .wb_data(b_wb_data), .flush(b_flush)
  );

  exp_t sbq[$];
  int   checks = 0;
  int   passes = 0;

  function automatic exp_t mk(logic [63:0] pc, logic [31:0] inst, logic [63:0] rs1,
                              logic [63:0] rs2, logic [63:0] imm, logic [4:0] rd,
                              logic rdwen, logic illegal);
    exp_t e;
    e.pc = pc; e.inst = inst; e.rs1 = rs1; e.rs2 = rs2; e.imm = imm;
    e.rd = rd; e.rdwen = rdwen; e.illegal = illegal;
    return e;
  endfunction

  function automatic exp_t obs_a();
    return mk(a_out_pc, a_out_inst, a_out_rs1data, a_out_rs2data, a_out_imm,
              a_out_rd, a_out_rdwen, a_out_illegal);
  endfunction

  function automatic exp_t obs_b();
    return mk({32'b0, b_out_pc}, b_out_inst, {32'b0, b_out_rs1data}, {32'b0, b_out_rs2data},
              {32'b0, b_out_imm}, b_out_rd, b_out_rdwen, b_out_illegal);
  endfunction

  // Offers one instruction, waits (bounded) for in_ready, pushes the expectation
  // on acceptance and returns at the negedge after the accepting edge.
  task automatic accept(input bit use_b, input logic [31:0] inst, input logic [63:0] pc,
                        input exp_t e, output bit ok);
    ok = 1'b0;
    if (use_b) begin b_in_inst = inst; b_in_pc = pc[31:0]; b_in_valid = 1'b1; end
    else begin a_in_inst = inst; a_in_pc = pc; a_in_valid = 1'b1; end
    for (int i = 0; i < 16 && !ok; i++) begin
      #1;
      if (use_b ? b_in_ready : a_in_ready) begin
        ok = 1'b1;
        sbq.push_back(e);
      end
      @(posedge clk);
      @(negedge clk);
    end
    a_in_valid = 1'b0;
    b_in_valid = 1'b0;
  endtask

  task automatic wb(input bit use_b, input logic [4:0] rd, input logic [63:0] data);
    if (use_b) begin b_wb_en = 1'b1; b_wb_rd = rd; b_wb_data = data[31:0]; end
    else begin a_wb_en = 1'b1; a_wb_rd = rd; a_wb_data = data; end
    @(posedge clk);
    @(negedge clk);
    a_wb_en = 1'b0;
    b_wb_en = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (a_out_valid !== 1'b0 || a_out_rdwen !== 1'b0 || a_out_illegal !== 1'b0) begin
      $display("[TB] FAIL reset_flags: got valid=%b rdwen=%b illegal=%b, need 0 0 0",
               a_out_valid, a_out_rdwen, a_out_illegal);
    end else passes++;
    checks++;
    if (obs_a() !== '0) $display("[TB] FAIL reset_data: got %h, need 0", obs_a());
    else passes++;
    checks++;
    if (a_in_ready !== 1'b1) $display("[TB] FAIL reset_ready: got %b, need 1", a_in_ready);
    else passes++;
    checks++;
    if (b_out_valid !== 1'b0 || obs_b() !== '0)
      $display("[TB] FAIL reset_b: got valid=%b data=%h, need 0", b_out_valid, obs_b());
    else passes++;
  endtask

  task automatic test_addi_bypass();
    bit ok, stalled;
    exp_t e;
    a_out_ready = 1'b1;
    accept(0, 32'h00500093, 64'h8000_0000, mk(64'h8000_0000, 32'h00500093, 0, 0, 5, 1, 1, 0), ok);
    checks++;
    if (!ok || sbq.size() == 0) $display("[TB] FAIL addi_x1: not accepted, need accept");
    else begin
      e = sbq.pop_front();
      if (a_out_valid !== 1'b1 || obs_a() !== e)
        $display("[TB] FAIL addi_x1: got %b/%h, need 1/%h", a_out_valid, obs_a(), e);
      else passes++;
    end
    a_in_inst = 32'hfff08113; a_in_pc = 64'h8000_0004; a_in_valid = 1'b1;
    stalled = 1'b1;
    repeat (3) begin
      #1;
      if (a_in_ready !== 1'b0) stalled = 1'b0;
      @(posedge clk);
      @(negedge clk);
    end
    checks++;
    if (!stalled) $display("[TB] FAIL raw_stall: got in_ready=1 before wb, need 0");
    else passes++;
    a_wb_en = 1'b1; a_wb_rd = 5'd1; a_wb_data = 64'd5;
    #1;
    checks++;
    if (a_in_ready !== 1'b1) $display("[TB] FAIL bypass_ready: got %b, need 1", a_in_ready);
    else begin
      passes++;
      sbq.push_back(mk(64'h8000_0004, 32'hfff08113, 5, 0, '1, 2, 1, 0));
    end
    @(posedge clk);
    @(negedge clk);
    a_wb_en = 1'b0; a_in_valid = 1'b0;
    checks++;
    if (sbq.size() == 0) $display("[TB] FAIL addi_bypass: nothing accepted, need accept");
    else begin
      e = sbq.pop_front();
      if (a_out_valid !== 1'b1 || obs_a() !== e)
        $display("[TB] FAIL addi_bypass: got %b/%h, need 1/%h", a_out_valid, obs_a(), e);
      else passes++;
    end
    a_in_inst = 32'h00108193;
    #1;
    checks++;
    if (a_in_ready !== 1'b1) $display("[TB] FAIL pend_x1_clear: got %b, need 1", a_in_ready);
    else passes++;
    a_in_inst = 32'h00110193;
    #1;
    checks++;
    if (a_in_ready !== 1'b0) $display("[TB] FAIL pend_x2_set: got %b, need 0", a_in_ready);
    else passes++;
    @(negedge clk);
    accept(0, 32'h00108193, 64'h8000_0008, mk(64'h8000_0008, 32'h00108193, 5, 0, 1, 3, 1, 0), ok);
    checks++;
    if (!ok || sbq.size() == 0) $display("[TB] FAIL array_read: not accepted, need accept");
    else begin
      e = sbq.pop_front();
      if (a_out_valid !== 1'b1 || obs_a() !== e)
        $display("[TB] FAIL array_read: got %b/%h, need 1/%h", a_out_valid, obs_a(), e);
      else passes++;
    end
    wb(0, 2, 4);
    wb(0, 3, 6);
  endtask

  task automatic test_lui();
    bit ok;
    exp_t e;
    accept(0, 32'h123451b7, 64'h8000_000c,
           mk(64'h8000_000c, 32'h123451b7, 0, 0, 64'h0000_0000_1234_5000, 3, 1, 0), ok);
    checks++;
    if (!ok || sbq.size() == 0) $display("[TB] FAIL lui64: not accepted, need accept");
    else begin
      e = sbq.pop_front();
      if (a_out_valid !== 1'b1 || obs_a() !== e)
        $display("[TB] FAIL lui64: got %b/%h, need 1/%h", a_out_valid, obs_a(), e);
      else passes++;
    end
    wb(0, 3, 64'h1234_5000);
  endtask

  task automatic test_x0_illegal();
    bit ok;
    exp_t e;
    a_wb_en = 1'b1; a_wb_rd = 5'd0; a_wb_data = 64'hDEAD;
    accept(0, 32'h00000293, 64'h8000_0010, mk(64'h8000_0010, 32'h00000293, 0, 0, 0, 5, 1, 0), ok);
    a_wb_en = 1'b0;
    checks++;
    if (!ok || sbq.size() == 0) $display("[TB] FAIL x0_read: not accepted, need accept");
    else begin
      e = sbq.pop_front();
      if (a_out_valid !== 1'b1 || obs_a() !== e)
        $display("[TB] FAIL x0_read: got %b/%h, need 1/%h", a_out_valid, obs_a(), e);
      else passes++;
    end
    accept(0, 32'h00000000, 64'h8000_0014, mk(64'h8000_0014, 0, 0, 0, 0, 0, 0, 1), ok);
    checks++;
    if (!ok || sbq.size() == 0) $display("[TB] FAIL illegal_zero: not accepted, need accept");
    else begin
      e = sbq.pop_front();
      if (a_out_valid !== 1'b1 || obs_a() !== e)
        $display("[TB] FAIL illegal_zero: got %b/%h, need 1/%h", a_out_valid, obs_a(), e);
      else passes++;
    end
    a_in_inst = 32'h00028313;
    #1;
    checks++;
    if (a_in_ready !== 1'b0) $display("[TB] FAIL pend_after_illegal: got %b, need 0", a_in_ready);
    else passes++;
    @(negedge clk);
    wb(0, 5, 0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] insts [3] = '{32'h00001437, 32'h000024b7, 32'h00001517};
    logic [63:0] imms  [3] = '{64'h1000, 64'h2000, 64'h1000};
    logic [4:0]  rds   [3] = '{5'd8, 5'd9, 5'd10};
    exp_t e;
    a_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a_in_inst = insts[i]; a_in_pc = 64'h9000_0000 + 64'(4 * i); a_in_valid = 1'b1;
      #1;
      if (a_in_ready === 1'b1)
        sbq.push_back(mk(64'h9000_0000 + 64'(4 * i), insts[i], 0, 0, imms[i], rds[i], 1, 0));
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (sbq.size() == 0) $display("[TB] FAIL b2b_%0d: stalled, need accept every cycle", i);
      else begin
        e = sbq.pop_front();
        if (a_out_valid !== 1'b1 || obs_a() !== e)
          $display("[TB] FAIL b2b_%0d: got %b/%h, need 1/%h", i, a_out_valid, obs_a(), e);
        else passes++;
      end
    end
    a_in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (a_out_valid !== 1'b0) $display("[TB] FAIL drain: got out_valid=%b, need 0", a_out_valid);
    else passes++;
    wb(0, 8, 1);
    wb(0, 9, 2);
    wb(0, 10, 3);
  endtask

  task automatic test_flush();
    bit ok;
    exp_t e;
    a_out_ready = 1'b0;
    e = mk(64'h8000_0020, 32'h00000293, 0, 0, 0, 5, 1, 0);
    accept(0, 32'h00000293, 64'h8000_0020, e, ok);
    if (sbq.size() != 0) void'(sbq.pop_front());
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (!ok || a_out_valid !== 1'b1 || obs_a() !== e)
      $display("[TB] FAIL hold_stable: got %b/%h, need 1/%h", a_out_valid, obs_a(), e);
    else passes++;
    a_out_ready = 1'b1; a_flush = 1'b1;
    a_in_inst = 32'h00000393; a_in_valid = 1'b1;
    #1;
    checks++;
    if (a_in_ready !== 1'b0) $display("[TB] FAIL flush_ready: got %b, need 0", a_in_ready);
    else passes++;
    @(posedge clk);
    @(negedge clk);
    a_flush = 1'b0; a_in_valid = 1'b0;
    checks++;
    if (a_out_valid !== 1'b0) $display("[TB] FAIL flush_clear: got out_valid=%b, need 0", a_out_valid);
    else passes++;
    a_in_inst = 32'h00028313;
    #1;
    checks++;
    if (a_in_ready !== 1'b1) $display("[TB] FAIL flush_pending: got in_ready=%b, need 1", a_in_ready);
    else passes++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_stall();
    bit ok;
    exp_t e;
    a_out_ready = 1'b1;
    accept(0, 32'h00500093, 64'h8000_0030, mk(64'h8000_0030, 32'h00500093, 0, 0, 5, 1, 1, 0), ok);
    if (sbq.size() != 0) void'(sbq.pop_front());
    a_in_inst = 32'hfff08113; a_in_pc = 64'h8000_0034; a_in_valid = 1'b1;
    #1;
    checks++;
    if (!ok || a_in_ready !== 1'b0) $display("[TB] FAIL rst_stall: got ok=%b ready=%b, need 1 0", ok, a_in_ready);
    else passes++;
    rst = 1'b1;
    #1;
    checks++;
    if (a_out_valid !== 1'b0 || obs_a() !== '0)
      $display("[TB] FAIL rst_outputs: got %b/%h, need 0/0", a_out_valid, obs_a());
    else passes++;
    sbq.delete();
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (a_in_ready !== 1'b1) $display("[TB] FAIL rst_first_ready: got %b, need 1", a_in_ready);
    else begin
      passes++;
      sbq.push_back(mk(64'h8000_0034, 32'hfff08113, 0, 0, '1, 2, 1, 0));
    end
    @(posedge clk);
    @(negedge clk);
    a_in_valid = 1'b0;
    checks++;
    if (sbq.size() == 0) $display("[TB] FAIL rst_first_accept: nothing accepted, need accept");
    else begin
      e = sbq.pop_front();
      if (a_out_valid !== 1'b1 || obs_a() !== e)
        $display("[TB] FAIL rst_first_accept: got %b/%h, need 1/%h", a_out_valid, obs_a(), e);
      else passes++;
    end
    wb(0, 2, 0);
  endtask

  task automatic test_xlen32_sb1();
    bit ok, stalled;
    exp_t e;
    b_out_ready = 1'b1;
    accept(1, 32'h123451b7, 64'h100, mk(64'h100, 32'h123451b7, 0, 0, 64'h1234_5000, 3, 1, 0), ok);
    checks++;
    if (!ok || sbq.size() == 0) $display("[TB] FAIL lui32: not accepted, need accept");
    else begin
      e = sbq.pop_front();
      if (b_out_valid !== 1'b1 || obs_b() !== e)
        $display("[TB] FAIL lui32: got %b/%h, need 1/%h", b_out_valid, obs_b(), e);
      else passes++;
    end
    accept(1, 32'h0000001b, 64'h104, mk(64'h104, 32'h0000001b, 0, 0, 0, 0, 0, 1), ok);
    checks++;
    if (!ok || sbq.size() == 0) $display("[TB] FAIL opimm32_illegal: not accepted, need accept");
    else begin
      e = sbq.pop_front();
      if (b_out_valid !== 1'b1 || obs_b() !== e)
        $display("[TB] FAIL opimm32_illegal: got %b/%h, need 1/%h", b_out_valid, obs_b(), e);
      else passes++;
    end
    accept(1, 32'h00500093, 64'h108, mk(64'h108, 32'h00500093, 0, 0, 5, 1, 1, 0), ok);
    if (sbq.size() != 0) void'(sbq.pop_front());
    b_in_inst = 32'h00700093; b_in_pc = 32'h10c; b_in_valid = 1'b1;
    stalled = ok;
    repeat (2) begin
      #1;
      if (b_in_ready !== 1'b0) stalled = 1'b0;
      @(posedge clk);
      @(negedge clk);
    end
    checks++;
    if (!stalled) $display("[TB] FAIL sb1_full: got in_ready=1 with x1 pending, need 0");
    else passes++;
    wb(1, 1, 5);
    #1;
    checks++;
    if (b_in_ready !== 1'b1) $display("[TB] FAIL sb1_release: got %b, need 1", b_in_ready);
    else begin
      passes++;
      sbq.push_back(mk(64'h10c, 32'h00700093, 0, 0, 7, 1, 1, 0));
    end
    @(posedge clk);
    @(negedge clk);
    b_in_valid = 1'b0;
    checks++;
    if (sbq.size() == 0) $display("[TB] FAIL sb1_second: nothing accepted, need accept");
    else begin
      e = sbq.pop_front();
      if (b_out_valid !== 1'b1 || obs_b() !== e)
        $display("[TB] FAIL sb1_second: got %b/%h, need 1/%h", b_out_valid, obs_b(), e);
      else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_addi_bypass();
    test_lui();
    test_x0_illegal();
    test_back_to_back();
    test_flush();
    test_reset_mid_stall();
    test_xlen32_sb1();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, need completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
